// File: rtl/lsu_wb_master.sv
// MEM-stage load/store master: one Wishbone B4 classic cycle per access, aligned/extended load data.
// Latency: stall_pipl for 1 + REQ cycles (2 minimum); pipeline back-pressure is stall_pipl until DONE.
module lsu_wb_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_read_mem,
  input  logic        mem_write_mem,
  input  logic [2:0]  fun3_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] wdata_mem,
  output logic [31:0] rdata_mem,
  output logic        stall_pipl,
  output logic        misaligned,
  output logic        bus_fault,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [2:0]  fun3_q;
  logic [1:0]  a_q;
  logic [31:0] rdat_q;
  logic        fault_q;

  logic        req, mis, is_half, is_word, accept;
  logic [3:0]  sel_c;
  logic [31:0] dat_c;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Reserved encodings (011, 11x) fall into the word class via fun3[1].
  assign req     = mem_read_mem | mem_write_mem;
  assign is_half = (fun3_mem[1:0] == 2'b01);
  assign is_word = fun3_mem[1];
  assign mis     = req & ((is_half & addr_mem[0]) | (is_word & (addr_mem[1:0] != 2'b00)));
  assign accept  = (state == IDLE) & req & ~mis;

  always_comb begin
    sel_c = 4'b1111;
    dat_c = wdata_mem;
    if (!is_word) begin
      if (is_half) begin
        sel_c = 4'b0011 << addr_mem[1:0];
        dat_c = {2{wdata_mem[15:0]}};
      end else begin
        sel_c = 4'b0001 << addr_mem[1:0];
        dat_c = {4{wdata_mem[7:0]}};
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    stall_pipl = 1'b0;
    misaligned = 1'b0;
    bus_fault  = 1'b0;
    case (state)
      IDLE: begin
        misaligned = mis;
        if (req && !mis) begin
          stall_pipl = 1'b1;
          state_nxt  = REQ;
        end
      end
      REQ: begin
        stall_pipl = 1'b1;
        if (wb_err_i || wb_ack_i || (cnt == TO_LAST)) state_nxt = DONE;
      end
      DONE: begin
        bus_fault = fault_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= 32'd0;
      wb_dat_o <= 32'd0;
      wb_sel_o <= 4'd0;
      fun3_q   <= 3'd0;
      a_q      <= 2'd0;
      rdat_q   <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        wb_we_o  <= mem_write_mem;
        wb_adr_o <= {addr_mem[31:2], 2'b00};
        wb_dat_o <= dat_c;
        wb_sel_o <= sel_c;
        fun3_q   <= fun3_mem;
        a_q      <= addr_mem[1:0];
        rdat_q   <= 32'd0;
        fault_q  <= 1'b0;
      end else if (state == REQ) begin
        if (state_nxt == DONE) begin
          wb_cyc_o <= 1'b0;
          wb_stb_o <= 1'b0;
          cnt      <= 8'd0;
          // Error beats ack; a faulted or store access leaves zero behind.
          fault_q  <= wb_err_i | ~wb_ack_i;
          rdat_q   <= (wb_ack_i && !wb_err_i && !wb_we_o) ? wb_dat_i : 32'd0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign byte_v = rdat_q[{a_q, 3'b000} +: 8];
  assign half_v = rdat_q[{a_q[1], 4'b0000} +: 16];

  always_comb begin
    case (fun3_q)
      3'b000:  rdata_mem = {{24{byte_v[7]}}, byte_v};
      3'b001:  rdata_mem = {{16{half_v[15]}}, half_v};
      3'b100:  rdata_mem = {24'd0, byte_v};
      3'b101:  rdata_mem = {16'd0, half_v};
      default: rdata_mem = rdat_q;
    endcase
  end

endmodule
